// File: rtl/sysid_regs_ext.sv
// -----------------------------------------------------------------------------
// sysid_regs_ext
//
// Avalon-MM control slave that reports the system ID and build timestamp and
// provides a byte-writable scratch register, a 64-bit prescaled uptime counter
// with an atomic high-word snapshot, and a pipelined read path with a fixed
// READ_LATENCY.
//
// Optional feature: define SYSID_ALARM_EN to build the ALARM/STATUS registers
// and the alarm interrupt. Without it ALARM and STATUS read 0, writes to them
// are ignored and irq is tied low.
//
// Word map:
//   0 ID (RO)              4 UPTIME_HI_SNAP (RO)
//   1 TIMESTAMP (RO)       5 CONTROL: [0] count_en, [1] clear (W1, reads 0),
//   2 SCRATCH (RW, byteen)            [2] irq_en
//   3 UPTIME_LO (RO)       6 ALARM (RW)   7 STATUS: [0] alarm_flag (W1C)
//
// Ports:
//   clock          system clock
//   reset          synchronous, active-high reset
//   address        word address
//   read           read strobe, one transfer per cycle, no waitrequest
//   write          write strobe
//   writedata      write data
//   byteenable     byte lanes for writes (honoured by SCRATCH only)
//   readdata       read data, 0 whenever readdatavalid is low
//   readdatavalid  read data qualifier, READ_LATENCY cycles after the read
//   irq            level interrupt, active-high
// -----------------------------------------------------------------------------
module sysid_regs_ext #(
  parameter logic [31:0] SYSTEM_ID    = 32'h582E_0C7D,
  parameter logic [31:0] TIMESTAMP    = 32'd1479449597,
  parameter int          ADDR_W       = 3,
  parameter int          READ_LATENCY = 1,
  parameter int          PRESCALE     = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] A_ID      = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_TSTAMP  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_SCRATCH = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_UP_LO   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_UP_HI   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_CONTROL = ADDR_W'(5);
`ifdef SYSID_ALARM_EN
  localparam logic [ADDR_W-1:0] A_ALARM   = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(7);
`endif
  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic [31:0] scratch;
  logic [63:0] uptime;
  logic [63:0] uptime_inc;
  logic [31:0] snapshot;
  logic [15:0] pre_cnt;
  logic        count_en;
  logic        irq_en;
  logic        clear;
  logic        tick;
  logic [31:0] rd_val;

  // Read pipeline: valid bits are reset so in-flight reads die on reset.
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [31:0]             pipe_data [READ_LATENCY];

`ifdef SYSID_ALARM_EN
  logic [31:0] alarm;
  logic        alarm_flag;
  logic        irq_q;
  logic        alarm_hit;
  logic        flag_w1c;
`endif

  assign clear      = write && (address == A_CONTROL) && writedata[1];
  // tick marks a cycle in which the prescaler wraps and uptime would advance.
  assign tick       = count_en && (pre_cnt == PRE_MAX);
  assign uptime_inc = uptime + 64'd1;

  // Register readback sampled from pre-write state, so a same-cycle write to
  // the addressed register is not visible to this read.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    rd_val = '0;
    case (address)
      A_ID:      rd_val = SYSTEM_ID;
      A_TSTAMP:  rd_val = TIMESTAMP;
      A_SCRATCH: rd_val = scratch;
      A_UP_LO:   rd_val = uptime[31:0];
      A_UP_HI:   rd_val = snapshot;
      A_CONTROL: rd_val = {29'd0, irq_en, 1'b0, count_en};
`ifdef SYSID_ALARM_EN
      A_ALARM:   rd_val = alarm;
      A_STATUS:  rd_val = {31'd0, alarm_flag};
`endif
      default:   rd_val = '0;
    endcase
  end

  // Control, scratch, uptime and snapshot state.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      scratch  <= '0;
      uptime   <= '0;
      snapshot <= '0;
      pre_cnt  <= '0;
      count_en <= 1'b1;
      irq_en   <= 1'b0;
    end else begin
      if (write && (address == A_SCRATCH)) begin
        for (int b = 0; b < 4; b++) begin
          if (byteenable[b]) scratch[b*8 +: 8] <= writedata[b*8 +: 8];
        end
      end
      if (write && (address == A_CONTROL)) begin
        count_en <= writedata[0];
        irq_en   <= writedata[2];
      end
      // Reading the low word freezes the matching high word for word 4.
      if (read && (address == A_UP_LO)) snapshot <= uptime[63:32];
      // Clear beats an increment due in the same cycle.
      if (clear) begin
        pre_cnt <= '0;
        uptime  <= '0;
      end else if (count_en) begin
        if (tick) begin
          pre_cnt <= '0;
          uptime  <= uptime_inc;
        end else begin
          pre_cnt <= pre_cnt + 16'd1;
        end
      end
    end
  end

`ifdef SYSID_ALARM_EN
  assign alarm_hit = tick && !clear && (uptime_inc[31:0] == alarm);
  assign flag_w1c  = write && (address == A_STATUS) && writedata[0];

  always_ff @(posedge clock) begin
    if (reset) begin
      alarm      <= 32'hFFFF_FFFF;
      alarm_flag <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      if (write && (address == A_ALARM)) alarm <= writedata;
      // A new match wins over a coincident W1C.
      if (alarm_hit)     alarm_flag <= 1'b1;
      else if (flag_w1c) alarm_flag <= 1'b0;
      irq_q <= alarm_flag && irq_en;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= read;
      for (int i = 1; i < READ_LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  // NOTE: the data stages are deliberately not reset; the output is gated by
  // the valid bits, so stale contents are never visible.
  always_ff @(posedge clock) begin
    pipe_data[0] <= rd_val;
    for (int i = 1; i < READ_LATENCY; i++) pipe_data[i] <= pipe_data[i-1];
  end

  assign readdatavalid = pipe_vld[READ_LATENCY-1];
  assign readdata      = pipe_vld[READ_LATENCY-1] ? pipe_data[READ_LATENCY-1] : '0;

endmodule

// File: tb/tb_sysid_regs_ext.sv
// -----------------------------------------------------------------------------
// tb_sysid_regs_ext
//
// Self-checking bench for sysid_regs_ext with READ_LATENCY=2 and PRESCALE=4.
// A reference model tracks the number of enabled clocks since the last clear
// and derives uptime from it arithmetically; every read it predicts is queued
// with its delivery cycle and compared on the falling edge, along with irq.
// Directed table vectors and hand-written sequences cover the corner cases,
// then randomized traffic (including resets mid-pipeline) runs against the
// model. The alarm sequences are built only when SYSID_ALARM_EN is defined.
// -----------------------------------------------------------------------------
module tb_sysid_regs_ext;

  localparam int               RL   = 2;
  localparam int               PS   = 4;
  localparam longint unsigned  PSL  = 64'(PS);
  localparam logic [31:0]      SID  = 32'h582E_0C7D;
  localparam logic [31:0]      TS   = 32'd1479449597;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        irq;

  sysid_regs_ext #(
    .SYSTEM_ID   (SID),
    .TIMESTAMP   (TS),
    .ADDR_W      (3),
    .READ_LATENCY(RL),
    .PRESCALE    (PS)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .byteenable   (byteenable),
    .readdata     (readdata),
    .readdatavalid(readdatavalid),
    .irq          (irq)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  bit mon_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } beat_t;

  beat_t           q[$];
  int unsigned     cyc = 0;
  longint unsigned m_ticks = 0;   // enabled clocks since last clear
  logic [31:0]     m_scratch = '0;
  logic [31:0]     m_snap = '0;
  logic [31:0]     m_alarm = 32'hFFFF_FFFF;
  logic            m_en = 1'b1;
  logic            m_irqen = 1'b0;
  logic            m_flag = 1'b0;
  logic            m_irq = 1'b0;

  function automatic logic [63:0] m_uptime();
    return m_ticks / PSL;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    logic [63:0] u;
    u = m_uptime();
    case (a)
      3'd0: return SID;
      3'd1: return TS;
      3'd2: return m_scratch;
      3'd3: return u[31:0];
      3'd4: return m_snap;
      3'd5: return {29'd0, m_irqen, 1'b0, m_en};
`ifdef SYSID_ALARM_EN
      3'd6: return m_alarm;
      3'd7: return {31'd0, m_flag};
`endif
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clock) begin : model_p
    logic [31:0] rv;
    logic [63:0] u;
    logic        set;
    logic        irq_next;
    cyc++;
    if (reset) begin
      q.delete();
      m_ticks = 0; m_scratch = '0; m_snap = '0; m_alarm = 32'hFFFF_FFFF;
      m_en = 1'b1; m_irqen = 1'b0; m_flag = 1'b0; m_irq = 1'b0;
    end else begin
      // Everything below is evaluated against pre-edge state first.
      u        = m_uptime();
      irq_next = m_flag & m_irqen;
      set      = 1'b0;
      if (read) begin
        rv = m_read(address);
        q.push_back('{cyc + RL - 1, rv});
        if (address == 3'd3) m_snap = u[63:32];
      end
      if (write && address == 3'd5 && writedata[1]) begin
        m_ticks = 0;
      end else if (m_en) begin
        m_ticks++;
        u = m_uptime();
        if ((m_ticks % PSL) == 0 && u[31:0] == m_alarm) set = 1'b1;
      end
      if (write) begin
        case (address)
          3'd2: for (int b = 0; b < 4; b++)
                  if (byteenable[b]) m_scratch[b*8 +: 8] = writedata[b*8 +: 8];
          3'd5: begin m_en = writedata[0]; m_irqen = writedata[2]; end
`ifdef SYSID_ALARM_EN
          3'd6: m_alarm = writedata;
          3'd7: if (writedata[0]) m_flag = 1'b0;
`endif
          default: ;
        endcase
      end
`ifdef SYSID_ALARM_EN
      if (set) m_flag = 1'b1;
      m_irq = irq_next;
`else
      m_irq = 1'b0;
`endif
    end
  end

  // Cycle-by-cycle comparison of the read port and irq against the model.
  always @(negedge clock) begin
    if (mon_on) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        check("mon_valid", {31'd0, readdatavalid}, 32'd1);
        check("mon_data", readdata, q[0].data);
        void'(q.pop_front());
      end else begin
        check("mon_idle_valid", {31'd0, readdatavalid}, 32'd0);
        check("mon_idle_data", readdata, 32'd0);
      end
      check("mon_irq", {31'd0, irq}, {31'd0, m_irq});
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic step(input logic rd, input logic wr, input logic [2:0] a,
                      input logic [31:0] wd, input logic [3:0] be);
    read = rd; write = wr; address = a; writedata = wd; byteenable = be;
    @(posedge clock);
    @(negedge clock);
    read = 1'b0; write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
  endtask

  task automatic wr_word(input logic [2:0] a, input logic [31:0] wd);
    step(1'b0, 1'b1, a, wd, 4'hF);
  endtask

  task automatic rd_word(input logic [2:0] a, output logic [31:0] d);
    step(1'b1, 1'b0, a, 32'd0, 4'd0);
    idle(RL - 1);
    check("rd_word_valid", {31'd0, readdatavalid}, 32'd1);
    d = readdata;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t        vt[21];
  logic [31:0] d;
  logic [31:0] v;
  logic [31:0] alm_rst;

  initial begin
`ifdef SYSID_ALARM_EN
    alm_rst = 32'hFFFF_FFFF;
`else
    alm_rst = 32'd0;
`endif
    vt[0]  = '{1'b0, 3'd0, 32'd0,          4'h0, SID};
    vt[1]  = '{1'b0, 3'd1, 32'd0,          4'h0, TS};
    vt[2]  = '{1'b0, 3'd2, 32'd0,          4'h0, 32'd0};
    vt[3]  = '{1'b0, 3'd4, 32'd0,          4'h0, 32'd0};
    vt[4]  = '{1'b0, 3'd5, 32'd0,          4'h0, 32'd1};
    vt[5]  = '{1'b0, 3'd6, 32'd0,          4'h0, alm_rst};
    vt[6]  = '{1'b0, 3'd7, 32'd0,          4'h0, 32'd0};
    vt[7]  = '{1'b1, 3'd2, 32'hAABB_CCDD,  4'hF, 32'd0};
    vt[8]  = '{1'b1, 3'd2, 32'h1122_3344,  4'h5, 32'd0};
    vt[9]  = '{1'b0, 3'd2, 32'd0,          4'h0, 32'hAA22_CC44};
    vt[10] = '{1'b1, 3'd0, 32'h1234_5678,  4'hF, 32'd0};
    vt[11] = '{1'b0, 3'd0, 32'd0,          4'h0, SID};
    vt[12] = '{1'b1, 3'd2, 32'hFFFF_FFFF,  4'h8, 32'd0};
    vt[13] = '{1'b0, 3'd2, 32'd0,          4'h0, 32'hFF22_CC44};
    vt[14] = '{1'b1, 3'd5, 32'd5,          4'h0, 32'd0};
    vt[15] = '{1'b0, 3'd5, 32'd0,          4'h0, 32'd5};
    vt[16] = '{1'b1, 3'd5, 32'd1,          4'h1, 32'd0};
    vt[17] = '{1'b0, 3'd5, 32'd0,          4'h0, 32'd1};
    vt[18] = '{1'b1, 3'd6, 32'h0000_1234,  4'h3, 32'd0};
    vt[19] = '{1'b0, 3'd6, 32'd0,          4'h0, (alm_rst != 0) ? 32'h0000_1234 : 32'd0};
    vt[20] = '{1'b1, 3'd6, 32'hFFFF_FFFF,  4'hF, 32'd0};

    @(negedge clock);
    do_reset();
    mon_on = 1'b1;

    // Single read, latency 2: valid only on the second edge after the read.
    step(1'b1, 1'b0, 3'd0, 32'd0, 4'd0);
    check("lat_edge1_valid", {31'd0, readdatavalid}, 32'd0);
    check("lat_edge1_data", readdata, 32'd0);
    idle(1);
    check("lat_edge2_valid", {31'd0, readdatavalid}, 32'd1);
    check("lat_edge2_data", readdata, SID);
    idle(1);
    check("lat_edge3_valid", {31'd0, readdatavalid}, 32'd0);
    check("lat_edge3_data", readdata, 32'd0);

    // Back-to-back reads of words 0, 1, 2.
    step(1'b1, 1'b0, 3'd0, 32'd0, 4'd0);
    step(1'b1, 1'b0, 3'd1, 32'd0, 4'd0);
    check("b2b_0", readdata, SID);
    step(1'b1, 1'b0, 3'd2, 32'd0, 4'd0);
    check("b2b_1", readdata, TS);
    idle(1);
    check("b2b_2_valid", {31'd0, readdatavalid}, 32'd1);
    check("b2b_2", readdata, 32'd0);
    idle(1);
    check("b2b_end_valid", {31'd0, readdatavalid}, 32'd0);

    // Table-driven register access.
    do_reset();
    foreach (vt[i]) begin
      if (vt[i].wr) begin
        step(1'b0, 1'b1, vt[i].addr, vt[i].wd, vt[i].be);
      end else begin
        rd_word(vt[i].addr, d);
        check($sformatf("vec%0d_addr%0d", i, vt[i].addr), d, vt[i].exp);
      end
    end

    // Uptime after 40 clocks at prescale 4, then the snapshot high word.
    do_reset();
    idle(40);
    rd_word(3'd3, d);
    check("uptime_40clk", d, 32'd10);
    rd_word(3'd4, d);
    check("uptime_snap_hi", d, 32'd0);

    // Clear coincident with a due increment, then freeze with count_en=0.
    do_reset();
    idle(3);
    wr_word(3'd5, 32'd3);
    rd_word(3'd3, d);
    check("clear_zero", d, 32'd0);
    idle(12);
    rd_word(3'd3, d);
    check("clear_counts_on", d, 32'd3);
    wr_word(3'd5, 32'd0);
    rd_word(3'd3, v);
    check("freeze_value", v, 32'd4);
    idle(100);
    rd_word(3'd3, d);
    check("freeze_held", d, v);
    rd_word(3'd5, d);
    check("control_off", d, 32'd0);
    wr_word(3'd5, 32'd1);

`ifdef SYSID_ALARM_EN
    begin : alarm_seq
      int n;
      logic [63:0] u;
      do_reset();
      wr_word(3'd6, 32'd5);
      wr_word(3'd5, 32'd5);
      n = 0;
      while (irq !== 1'b1 && n < 100) begin idle(1); n++; end
      check("alarm_irq_rise", {31'd0, irq}, 32'd1);
      rd_word(3'd7, d);
      check("alarm_flag_set", d, 32'd1);
      wr_word(3'd7, 32'd1);
      idle(1);
      check("alarm_irq_clear", {31'd0, irq}, 32'd0);
      rd_word(3'd7, d);
      check("alarm_flag_cleared", d, 32'd0);
      // W1C landing on the same edge as a fresh match: set must win.
      u = m_uptime();
      wr_word(3'd6, u[31:0] + 32'd2);
      n = 0;
      u = (m_ticks + 1) / PSL;
      while (!(((m_ticks + 1) % PSL) == 0 && u[31:0] == m_alarm) && n < 100) begin
        idle(1);
        n++;
        u = (m_ticks + 1) / PSL;
      end
      if (n >= 100) check("alarm_coinc_wait", 32'd0, 32'd1);
      wr_word(3'd7, 32'd1);
      rd_word(3'd7, d);
      check("alarm_coinc_set_wins", d, 32'd1);
      // Clearing uptime to 0 must not count as a match on ALARM=0.
      wr_word(3'd6, 32'd0);
      wr_word(3'd7, 32'd1);
      wr_word(3'd5, 32'd7);
      rd_word(3'd7, d);
      check("alarm_clear_no_match", d, 32'd0);
      wr_word(3'd6, 32'hFFFF_FFFF);
      wr_word(3'd5, 32'd1);
    end
`endif

    // Randomized traffic against the model, with occasional resets.
    do_reset();
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        logic [2:0]  a;
        logic [31:0] wd;
        a  = 3'($urandom_range(0, 7));
        wd = $urandom;
        if (a == 3'd5) begin
          wd[0] = ($urandom_range(0, 7) != 0);
          wd[1] = ($urandom_range(0, 15) == 0);
        end
        if (a == 3'd6) wd = 32'($urandom_range(0, 40));
        step(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), a, wd,
             4'($urandom_range(0, 15)));
      end
    end
    idle(RL + 1);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
